signal_lamp_driver: RTL and testbench
=====================================

Name: signal_lamp_driver

Overview:
Consumer of the traffic-controller state bus. Decodes the 2-bit phase code into red/amber/green lamp drives and a 2-digit multiplexed seven-segment countdown of whole seconds left in the current phase. Sits downstream of the phase sequencer on the same 1 kHz tick clock. Detects illegal phase codes and enters a fail-safe flashing-red mode.

Parameters:
PHASE_SEC, 2, seconds loaded into the countdown on every phase change; legal range 1..99
MS_PER_SEC, 1000, clk_1KHz cycles per displayed second
MUX_MS, 5, cycles each digit is enabled before switching to the other digit
BLINK_MS, 250, half-period of amber blink in DASH and red flash in fault

Ports:
clk_1KHz  in  1  1 kHz tick clock; all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
fsm_state  in  2  phase code: 0=STOP, 1=DASH, 2=GO, 3=illegal
lamp_red  out  1  red lamp on, active-high
lamp_amber  out  1  amber lamp on, active-high
lamp_green  out  1  green lamp on, active-high
seg  out  7  segments {g,f,e,d,c,b,a}, active-high
digit_en  out  2  digit anode enables, active-low; [1]=tens, [0]=units
state_err  out  1  sticky illegal-code flag

Behaviour:
- Reset (async assert, sync release): state_q=STOP, prev_q=STOP, sec_left=PHASE_SEC, ms_cnt=0, mux_cnt=0, blink_cnt=0, blink=0. Outputs: lamp_red=1, lamp_amber=0, lamp_green=0, digit_en=2'b10 (units enabled), seg=font(PHASE_SEC%10), state_err=0.
- Input stage: fsm_state is registered into state_q every cycle. prev_q holds the previous state_q. Change detect: chg = (state_q != prev_q).
- Countdown: on chg, sec_left<=PHASE_SEC and ms_cnt<=0. Otherwise ms_cnt increments. When ms_cnt==MS_PER_SEC-1, ms_cnt<=0 and sec_left decrements, saturating at 0 (no wrap).
- Lamps are registered from state_q, so a lamp changes on the 2nd rising edge after fsm_state changes.
  - STOP: red only.
  - GO: green only.
  - DASH: amber = blink; red and green off.
- Blink: blink_cnt counts 0..BLINK_MS-1. blink toggles at wrap. blink_cnt and blink clear to 0 on chg, so amber starts off for the first BLINK_MS cycles of DASH.
- Illegal code (state_q==3):
  - state_err<=1 on the same edge; sticky until rst_n.
  - While state_q==3: red = blink, amber = green = 0, seg = dash pattern (g only) on both digits.
  - When a legal code returns, normal decode resumes via chg; state_err stays 1.
- Display mux:
  - mux_cnt counts 0..MUX_MS-1. At wrap, the active digit swaps: digit_en alternates 2'b10 / 2'b01, never 2'b00.
  - seg is registered together with digit_en. Units digit shows sec_left%10; tens digit shows sec_left/10.
  - Leading zero blanked: tens digit with value 0 gives seg=0 while still enabled.
  - The mux free-runs and is not reset by chg.
- Simultaneous chg and ms wrap: chg wins (reload).
- Reset mid-phase: all counters return to reset values immediately; no partial second survives.

Optional Feature:
LAMP_TEST_EN:
- Defined: adds input port lamp_test (1 bit). While it is 1, lamp_red, lamp_amber and lamp_green = 1, seg=7'h7F, and the mux keeps alternating digits. Counters keep running underneath, and normal outputs resume on the next edge after lamp_test drops. state_err is unaffected.
- Undefined: no port and no logic.

Decomposition:
- Shared package signal_pkg holds:
  - phase codes STATE_STOP/DASH/GO/ILLEGAL (2 bit)
  - SEG_BLANK=7'h00, SEG_DASH=7'h40, SEG_ALL=7'h7F
  - 4-bit-to-segment font function for digits 0-9
- One natural sub-module: seg7_encode, a combinational 4-bit BCD in to 7-bit seg out, with blank for values above 9. It is also reusable by other display blocks.

Test Plan:
- Reset then fsm_state=0 held -> lamp_red=1. Display reads "2" (units digit, tens blanked) for 1000 cycles, then "1", then "0" held; never wraps.
- fsm_state 0→2 at cycle T -> lamp_green=1 and lamp_red=0 at edge T+2; sec_left reloads to 2.
- fsm_state=1 held for 2000 cycles -> lamp_amber is low for 250 cycles, high for 250, and so on (4 high pulses); red and green stay 0.
- PHASE_SEC=12 -> digit_en alternates every 5 cycles. Tens shows font(1), units shows font(2). After 3000 cycles, tens is blank and units shows font(9).
- fsm_state=3 for 600 cycles, then 2 -> state_err=1 from edge 1 and stays set. Red flashes at 250 ms, seg=7'h40 on both digits, then green lamp with count "2".
- rst_n pulsed low mid-DASH -> outputs go to reset values asynchronously without waiting for a clock edge; the countdown restarts at PHASE_SEC after release.

Source files
------------

// File: rtl/signal_pkg.sv
// Shared phase codes, segment constants and the 0-9 seven-segment font
// used by the signal-lamp display blocks.
package signal_pkg;

    typedef enum logic [1:0] {
        STATE_STOP    = 2'd0,
        STATE_DASH    = 2'd1,
        STATE_GO      = 2'd2,
        STATE_ILLEGAL = 2'd3
    } phase_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_ALL   = 7'h7F;

    // Segment order is {g,f,e,d,c,b,a}; anything above 9 is blank.
    function automatic logic [6:0] seg_font(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_font = 7'h3F;
            4'd1:    seg_font = 7'h06;
            4'd2:    seg_font = 7'h5B;
            4'd3:    seg_font = 7'h4F;
            4'd4:    seg_font = 7'h66;
            4'd5:    seg_font = 7'h6D;
            4'd6:    seg_font = 7'h7D;
            4'd7:    seg_font = 7'h07;
            4'd8:    seg_font = 7'h7F;
            4'd9:    seg_font = 7'h6F;
            default: seg_font = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD to seven-segment encoder; values above 9 are blanked.
module seg7_encode
    import signal_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_font(bcd);
    end

endmodule

// File: rtl/signal_lamp_driver.sv
// Lamp decoder and 2-digit countdown display for the traffic phase bus.
// Optional `define LAMP_TEST_EN adds a lamp_test input forcing every lamp and segment on.
module signal_lamp_driver
    import signal_pkg::*;
#(
    parameter int PHASE_SEC  = 2,
    parameter int MS_PER_SEC = 1000,
    parameter int MUX_MS     = 5,
    parameter int BLINK_MS   = 250
) (
    input  logic       clk_1KHz,
    input  logic       rst_n,
    input  logic [1:0] fsm_state,
`ifdef LAMP_TEST_EN
    input  logic       lamp_test,
`endif
    output logic       lamp_red,
    output logic       lamp_amber,
    output logic       lamp_green,
    output logic [6:0] seg,
    output logic [1:0] digit_en,
    output logic       state_err
);

    localparam int MS_W    = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
    localparam int MUX_W   = (MUX_MS > 1) ? $clog2(MUX_MS) : 1;
    localparam int BLINK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
    localparam int SEC_W   = 7;

    localparam logic [MS_W-1:0]    MS_LAST    = MS_W'(MS_PER_SEC - 1);
    localparam logic [MUX_W-1:0]   MUX_LAST   = MUX_W'(MUX_MS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MS - 1);
    localparam logic [SEC_W-1:0]   SEC_LOAD   = SEC_W'(PHASE_SEC);
    localparam logic [6:0]         RESET_SEG  = seg_font(4'(PHASE_SEC % 10));

    phase_t               state_q, prev_q;
    logic [MS_W-1:0]      ms_cnt, ms_n;
    logic [SEC_W-1:0]     sec_left, sec_n;
    logic [MUX_W-1:0]     mux_cnt, mux_n;
    logic [BLINK_W-1:0]   blink_cnt, blink_cnt_n;
    logic                 blink, blink_n;
    logic                 tens_sel, tens_sel_n;
    logic                 chg;
    logic [SEC_W-1:0]     tens_val, units_val;
    logic [3:0]           bcd_sel;
    logic [6:0]           seg_digit, seg_n;
    logic                 red_n, amber_n, green_n;

    assign chg = (state_q != prev_q);

    // Next-state of the timing counters; a phase change reloads everything it owns.
    always_comb begin
        ms_n        = ms_cnt;
        sec_n       = sec_left;
        blink_cnt_n = blink_cnt;
        blink_n     = blink;
        mux_n       = mux_cnt;
        tens_sel_n  = tens_sel;
        if (chg) begin
            ms_n        = '0;
            sec_n       = SEC_LOAD;
            blink_cnt_n = '0;
            blink_n     = 1'b0;
        end else begin
            if (ms_cnt == MS_LAST) begin
                ms_n = '0;
                if (sec_left != '0) sec_n = sec_left - 1'b1;
            end else begin
                ms_n = ms_cnt + 1'b1;
            end
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_n = '0;
                blink_n     = ~blink;
            end else begin
                blink_cnt_n = blink_cnt + 1'b1;
            end
        end
        if (mux_cnt == MUX_LAST) begin
            mux_n      = '0;
            tens_sel_n = ~tens_sel;
        end else begin
            mux_n = mux_cnt + 1'b1;
        end
    end

    assign tens_val  = sec_n / 7'd10;
    assign units_val = sec_n % 7'd10;
    assign bcd_sel   = tens_sel_n ? ((tens_val == '0) ? 4'hF : 4'(tens_val)) : 4'(units_val);

    seg7_encode u_seg7_encode (
        .bcd (bcd_sel),
        .seg (seg_digit)
    );

    // Output decode uses the next blink/count values so registered outputs line up with the counters.
    always_comb begin
        red_n   = 1'b0;
        amber_n = 1'b0;
        green_n = 1'b0;
        seg_n   = seg_digit;
        case (state_q)
            STATE_STOP: red_n   = 1'b1;
            STATE_GO:   green_n = 1'b1;
            STATE_DASH: amber_n = blink_n;
            default: begin
                red_n = blink_n;
                seg_n = SEG_DASH;
            end
        endcase
`ifdef LAMP_TEST_EN
        if (lamp_test) begin
            red_n   = 1'b1;
            amber_n = 1'b1;
            green_n = 1'b1;
            seg_n   = SEG_ALL;
        end
`endif
    end

    always_ff @(posedge clk_1KHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= STATE_STOP;
            prev_q     <= STATE_STOP;
            ms_cnt     <= '0;
            sec_left   <= SEC_LOAD;
            mux_cnt    <= '0;
            blink_cnt  <= '0;
            blink      <= 1'b0;
            tens_sel   <= 1'b0;
            lamp_red   <= 1'b1;
            lamp_amber <= 1'b0;
            lamp_green <= 1'b0;
            seg        <= RESET_SEG;
            digit_en   <= 2'b10;
            state_err  <= 1'b0;
        end else begin
            state_q    <= phase_t'(fsm_state);
            prev_q     <= state_q;
            ms_cnt     <= ms_n;
            sec_left   <= sec_n;
            mux_cnt    <= mux_n;
            blink_cnt  <= blink_cnt_n;
            blink      <= blink_n;
            tens_sel   <= tens_sel_n;
            lamp_red   <= red_n;
            lamp_amber <= amber_n;
            lamp_green <= green_n;
            seg        <= seg_n;
            digit_en   <= tens_sel_n ? 2'b01 : 2'b10;
            state_err  <= state_err | (fsm_state == STATE_ILLEGAL);
        end
    end

endmodule

// File: tb/tb_signal_lamp_driver.sv
// Self-checking bench for signal_lamp_driver: vector table with a scoreboard
// queue plus hand-written countdown, blink, fault and reset sequences.
module tb_signal_lamp_driver;

    logic       clk_1KHz = 1'b0;
    logic       rst_n;
    logic [1:0] fsm_state;
    logic [1:0] fsm12;
    logic       lamp_red, lamp_amber, lamp_green, state_err;
    logic [6:0] seg;
    logic [1:0] digit_en;
    logic       red12, amber12, green12, err12;
    logic [6:0] seg12;
    logic [1:0] den12;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0] st;
        logic       red;
        logic       amber;
        logic       green;
    } vec_t;

    typedef struct {
        logic red;
        logic amber;
        logic green;
        logic err;
        int   units;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[6];

    always #5 clk_1KHz = ~clk_1KHz;

    signal_lamp_driver dut (
        .clk_1KHz   (clk_1KHz),
        .rst_n      (rst_n),
        .fsm_state  (fsm_state),
`ifdef LAMP_TEST_EN
        .lamp_test  (1'b0),
`endif
        .lamp_red   (lamp_red),
        .lamp_amber (lamp_amber),
        .lamp_green (lamp_green),
        .seg        (seg),
        .digit_en   (digit_en),
        .state_err  (state_err)
    );

    signal_lamp_driver #(.PHASE_SEC(12)) dut12 (
        .clk_1KHz   (clk_1KHz),
        .rst_n      (rst_n),
        .fsm_state  (fsm12),
`ifdef LAMP_TEST_EN
        .lamp_test  (1'b0),
`endif
        .lamp_red   (red12),
        .lamp_amber (amber12),
        .lamp_green (green12),
        .seg        (seg12),
        .digit_en   (den12),
        .state_err  (err12)
    );

    function automatic logic [6:0] expFont(int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clk_1KHz);
        #1;
    endtask

    task automatic compare(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(vec_t v, logic err);
        exp_t e;
        fsm_state = v.st;
        e.red   = v.red;
        e.amber = v.amber;
        e.green = v.green;
        e.err   = err;
        e.units = 2;
        sbq.push_back(e);
    endtask

    task automatic checkOutput(string name);
        exp_t e;
        logic [6:0] expSeg;
        e = sbq.pop_front();
        expSeg = (digit_en == 2'b10) ? expFont(e.units) : 7'h00;
        compare({name, "_red"},   lamp_red,   e.red);
        compare({name, "_amber"}, lamp_amber, e.amber);
        compare({name, "_green"}, lamp_green, e.green);
        compare({name, "_err"},   state_err,  e.err);
        compare({name, "_seg"},   seg,        expSeg);
        compare({name, "_den_legal"}, int'(digit_en == 2'b10 || digit_en == 2'b01), 1);
    endtask

    initial begin
        int bad, bad12, badMux, rises, u, s12, ph;
        logic [1:0] expDen;
        logic [6:0] expSeg12;
        logic prevAmber;

        vecs[0] = '{STATE_STOP_C(), 1'b1, 1'b0, 1'b0};
        vecs[1] = '{2'd1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{2'd2, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{2'd1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{2'd0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{2'd2, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        fsm_state = 2'd0;
        fsm12 = 2'd0;
        #8;
        compare("rst_red",    lamp_red,   1);
        compare("rst_amber",  lamp_amber, 0);
        compare("rst_green",  lamp_green, 0);
        compare("rst_den",    digit_en,   2'b10);
        compare("rst_seg",    seg,        expFont(2));
        compare("rst_err",    state_err,  0);
        compare("rst_seg12",  seg12,      expFont(2));
        #4;
        rst_n = 1'b1;

        // Held STOP: 2,1,0 countdown with saturation; PHASE_SEC=12 instance checks both digits.
        bad = 0; bad12 = 0; badMux = 0;
        for (int k = 1; k <= 3200; k++) begin
            step(1);
            u = (k < 1000) ? 2 : (k < 2000) ? 1 : 0;
            expDen = (((k / 5) % 2) == 0) ? 2'b10 : 2'b01;
            if (digit_en !== expDen) badMux++;
            if (den12 !== expDen) badMux++;
            if (digit_en == 2'b10) begin
                if (seg !== expFont(u)) bad++;
            end else if (seg !== 7'h00) begin
                bad++;
            end
            if (lamp_red !== 1'b1) bad++;
            s12 = 12 - (k / 1000);
            if (den12 == 2'b10) expSeg12 = expFont(s12 % 10);
            else expSeg12 = ((s12 / 10) == 0) ? 7'h00 : expFont(s12 / 10);
            if (seg12 !== expSeg12) bad12++;
        end
        compare("countdown_errs", bad, 0);
        compare("mux_errs", badMux, 0);
        compare("phase12_errs", bad12, 0);
        compare("phase12_final_seg", seg12, (den12 == 2'b10) ? expFont(9) : 7'h00);

        // STOP -> GO latency: lamps move on the second edge.
        fsm_state = 2'd2;
        step(1);
        compare("lat_edge1_red",   lamp_red,   1);
        compare("lat_edge1_green", lamp_green, 0);
        step(1);
        compare("lat_edge2_red",   lamp_red,   0);
        compare("lat_edge2_green", lamp_green, 1);
        compare("lat_edge2_seg", seg, (digit_en == 2'b10) ? expFont(2) : 7'h00);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], 1'b0);
            step(2);
            checkOutput($sformatf("vec%0d", i));
            step(30);
        end
        compare("sb_drained", sbq.size(), 0);

        // DASH held 2000 cycles: amber 250 off / 250 on.
        fsm_state = 2'd1;
        step(2);
        bad = 0; rises = 0; prevAmber = 1'b0;
        for (int j = 0; j < 2000; j++) begin
            ph = (j / 250) % 2;
            if (lamp_amber !== ph[0]) bad++;
            if (lamp_red !== 1'b0 || lamp_green !== 1'b0) bad++;
            if (lamp_amber && !prevAmber) rises++;
            prevAmber = lamp_amber;
            step(1);
        end
        compare("dash_pattern_errs", bad, 0);
        compare("dash_pulses", rises, 4);

        // Illegal code for 600 cycles, then GO.
        fsm_state = 2'd3;
        step(1);
        compare("illegal_err_edge1", state_err, 1);
        step(1);
        bad = 0;
        for (int j = 0; j < 599; j++) begin
            ph = (j / 250) % 2;
            if (lamp_red !== ph[0]) bad++;
            if (lamp_amber !== 1'b0 || lamp_green !== 1'b0) bad++;
            if (seg !== 7'h40) bad++;
            if (state_err !== 1'b1) bad++;
            step(1);
        end
        compare("illegal_errs", bad, 0);
        fsm_state = 2'd2;
        step(2);
        compare("recover_green", lamp_green, 1);
        compare("recover_red",   lamp_red,   0);
        compare("recover_seg", seg, (digit_en == 2'b10) ? expFont(2) : 7'h00);
        step(50);
        compare("recover_err_sticky", state_err, 1);

        // Reset mid-DASH: outputs change without a clock edge, countdown restarts.
        fsm_state = 2'd1;
        step(400);
        #2;
        rst_n = 1'b0;
        #1;
        compare("arst_red",   lamp_red,   1);
        compare("arst_amber", lamp_amber, 0);
        compare("arst_green", lamp_green, 0);
        compare("arst_den",   digit_en,   2'b10);
        compare("arst_seg",   seg,        expFont(2));
        compare("arst_err",   state_err,  0);
        fsm_state = 2'd0;
        #3;
        rst_n = 1'b1;
        bad = 0;
        for (int k = 1; k <= 1005; k++) begin
            step(1);
            u = (k < 1000) ? 2 : 1;
            if (digit_en == 2'b10 && seg !== expFont(u)) bad++;
            if (lamp_red !== 1'b1) bad++;
        end
        compare("restart_countdown_errs", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    function automatic logic [1:0] STATE_STOP_C();
        return 2'd0;
    endfunction

endmodule
